// File: rtl/decode_queue_pkg.sv
// RV32I encoding types and OOPs inter-stage structs for the decode queue.
// rv32i_types holds encodings; oops_structs holds the decoded entry.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    f3_beq  = 3'b000,
    f3_bne  = 3'b001,
    f3_blt  = 3'b100,
    f3_bge  = 3'b101,
    f3_bltu = 3'b110,
    f3_bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    f3_lb  = 3'b000,
    f3_lh  = 3'b001,
    f3_lw  = 3'b010,
    f3_lbu = 3'b100,
    f3_lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    f3_sb = 3'b000,
    f3_sh = 3'b001,
    f3_sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    f3_add  = 3'b000,
    f3_sll  = 3'b001,
    f3_slt  = 3'b010,
    f3_sltu = 3'b011,
    f3_xor  = 3'b100,
    f3_sr   = 3'b101,
    f3_or   = 3'b110,
    f3_and  = 3'b111
  } arith_funct3_t;

  typedef enum logic [5:0] {
    i_illegal, i_lui, i_auipc, i_jal, i_jalr,
    i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu,
    i_lb, i_lh, i_lw, i_lbu, i_lhu,
    i_sb, i_sh, i_sw,
    imm_add, imm_slt, imm_sltu, imm_xor,
    imm_or, imm_and, imm_sll, imm_srl, imm_sra,
    reg_add, reg_sub, reg_sll, reg_slt, reg_sltu,
    reg_xor, reg_srl, reg_sra, reg_or, reg_and
  } rv32i_instr_t;

endpackage

package oops_structs;
  import rv32i_types::*;

  localparam int DECODE_Q_DEPTH = 4;

  typedef struct packed {
    rv32i_instr_t instr;
    logic [31:0]  pc;
    logic         cb1;
    logic         cb2;
    logic [31:0]  val1;
    logic [31:0]  val2;
    logic [4:0]   dest_reg;
    logic         branch;
    logic         jal;
    logic         jalr;
    logic [31:0]  b_imm;
  } instruction_element_t;

endpackage

// File: rtl/decode_queue_field_decode.sv
// Single-cycle RV32I field decoder: raw word + pc to a decoded entry.
// Purely combinational; flags encodings the core does not support.
module rv32i_field_decode
  import rv32i_types::*;
  import oops_structs::*;
(
  input  logic [31:0]          instr_i,
  input  logic [31:0]          pc_i,
  output instruction_element_t instruction_o,
  output logic                 illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        alt;
  logic [4:0]  rd;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign alt = instr_i[30];
  assign rd  = instr_i[11:7];
  assign rs1 = {27'd0, instr_i[19:15]};
  assign rs2 = {27'd0, instr_i[24:20]};

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25],
                  instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                  instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'd0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31],
                  instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  // Opcode/funct3 decode into the entry fields
  always_comb begin
    instruction_o       = '0;
    instruction_o.instr = i_illegal;
    instruction_o.pc    = pc_i;
    illegal             = 1'b0;
    case (opc)
      op_lui: begin
        instruction_o.instr    = i_lui;
        instruction_o.val2     = imm_u;
        instruction_o.dest_reg = rd;
      end
      op_auipc: begin
        instruction_o.instr    = i_auipc;
        instruction_o.val1     = pc_i;
        instruction_o.val2     = imm_u;
        instruction_o.dest_reg = rd;
      end
      op_br: begin
        instruction_o.cb1    = 1'b1;
        instruction_o.cb2    = 1'b1;
        instruction_o.val1   = rs1;
        instruction_o.val2   = rs2;
        instruction_o.branch = 1'b1;
        instruction_o.b_imm  = imm_b;
        case (f3)
          f3_beq:  instruction_o.instr = i_beq;
          f3_bne:  instruction_o.instr = i_bne;
          f3_blt:  instruction_o.instr = i_blt;
          f3_bge:  instruction_o.instr = i_bge;
          f3_bltu: instruction_o.instr = i_bltu;
          f3_bgeu: instruction_o.instr = i_bgeu;
          default: illegal = 1'b1;
        endcase
      end
      op_load: begin
        instruction_o.cb1      = 1'b1;
        instruction_o.val1     = rs1;
        instruction_o.b_imm    = imm_i;
        instruction_o.dest_reg = rd;
        case (f3)
          f3_lb:   instruction_o.instr = i_lb;
          f3_lh:   instruction_o.instr = i_lh;
          f3_lw:   instruction_o.instr = i_lw;
          f3_lbu:  instruction_o.instr = i_lbu;
          f3_lhu:  instruction_o.instr = i_lhu;
          default: illegal = 1'b1;
        endcase
      end
      op_store: begin
        instruction_o.cb1   = 1'b1;
        instruction_o.cb2   = 1'b1;
        instruction_o.val1  = rs1;
        instruction_o.val2  = rs2;
        instruction_o.b_imm = imm_s;
        case (f3)
          f3_sb:   instruction_o.instr = i_sb;
          f3_sh:   instruction_o.instr = i_sh;
          f3_sw:   instruction_o.instr = i_sw;
          default: illegal = 1'b1;
        endcase
      end
      op_imm: begin
        instruction_o.cb1      = 1'b1;
        instruction_o.val1     = rs1;
        instruction_o.val2     = imm_i;
        instruction_o.dest_reg = rd;
        case (f3)
          f3_add:  instruction_o.instr = imm_add;
          f3_sll:  instruction_o.instr = imm_sll;
          f3_slt:  instruction_o.instr = imm_slt;
          f3_sltu: instruction_o.instr = imm_sltu;
          f3_xor:  instruction_o.instr = imm_xor;
          f3_or:   instruction_o.instr = imm_or;
          f3_and:  instruction_o.instr = imm_and;
          default: instruction_o.instr =
                     alt ? imm_sra : imm_srl;
        endcase
      end
      op_reg: begin
        instruction_o.cb1      = 1'b1;
        instruction_o.cb2      = 1'b1;
        instruction_o.val1     = rs1;
        instruction_o.val2     = rs2;
        instruction_o.dest_reg = rd;
        case (f3)
          f3_add:  instruction_o.instr =
                     alt ? reg_sub : reg_add;
          f3_sll:  instruction_o.instr = reg_sll;
          f3_slt:  instruction_o.instr = reg_slt;
          f3_sltu: instruction_o.instr = reg_sltu;
          f3_xor:  instruction_o.instr = reg_xor;
          f3_or:   instruction_o.instr = reg_or;
          f3_and:  instruction_o.instr = reg_and;
          default: instruction_o.instr =
                     alt ? reg_sra : reg_srl;
        endcase
      end
      op_jal: begin
        instruction_o.instr    = i_jal;
        instruction_o.val1     = pc_i;
        instruction_o.val2     = imm_j;
        instruction_o.dest_reg = rd;
        instruction_o.branch   = 1'b1;
        instruction_o.jal      = 1'b1;
      end
      op_jalr: begin
        instruction_o.instr    = i_jalr;
        instruction_o.cb1      = 1'b1;
        instruction_o.val1     = rs1;
        instruction_o.val2     = imm_i;
        instruction_o.dest_reg = rd;
        instruction_o.branch   = 1'b1;
        instruction_o.jalr     = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: one-cycle RV32I decode into a DEPTH-entry FIFO.
// Optional same-cycle bypass when empty: DECODE_QUEUE_BYPASS_EN.
module decode_queue
  import rv32i_types::*;
  import oops_structs::*;
#(
  parameter int DEPTH = DECODE_Q_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fls,
  input  logic        in_vld_i,
  output logic        in_rdy_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        out_vld_o,
  input  logic        out_rdy_i,
  output logic [$bits(instruction_element_t)-1:0]
                      instruction_o,
  output logic [CNT_W-1:0] count_o,
  output logic        illegal_o
);

  localparam int PTR_W = $clog2(DEPTH);

  instruction_element_t mem [DEPTH];
  instruction_element_t dec;
  logic                 dec_ill;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 ill_q;
  logic                 push;
  logic                 pop;
  logic                 wr_en;
  logic                 rd_en;

  rv32i_field_decode u_dec (
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .instruction_o (dec),
    .illegal       (dec_ill)
  );

  assign in_rdy_o  = (count != CNT_W'(DEPTH));
  assign push      = in_vld_i & in_rdy_o;
  assign pop       = out_vld_o & out_rdy_i;
  assign count_o   = count;
  assign illegal_o = ill_q;

`ifdef DECODE_QUEUE_BYPASS_EN
  logic byp;
  assign byp = (count == '0) & in_vld_i & ~dec_ill;
  assign out_vld_o = (count != '0) | byp;
  assign instruction_o = byp ? dec : mem[rd_ptr];
  assign wr_en = push & ~dec_ill & ~(byp & out_rdy_i);
  assign rd_en = pop & ~byp;
`else
  assign out_vld_o = (count != '0);
  assign instruction_o = mem[rd_ptr];
  assign wr_en = push & ~dec_ill;
  assign rd_en = pop;
`endif

  // Pointers, occupancy and the illegal pulse
  always_ff @(posedge clk) begin
    if (rst | fls) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ill_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en & ~rd_en)
        count <= count + CNT_W'(1);
      else if (rd_en & ~wr_en)
        count <= count - CNT_W'(1);
      ill_q <= push & dec_ill;
    end
  end

  // Entry payload; not reset, pointers gate validity
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dec;
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed testbench for decode_queue (DEPTH = 4).
// Bypass checks follow DECODE_QUEUE_BYPASS_EN.
module tb_decode_queue;
  import rv32i_types::*;
  import oops_structs::*;

  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        fls;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        out_vld;
  logic        out_rdy;
  logic [$bits(instruction_element_t)-1:0] instr_o;
  logic [CNT_W-1:0] count;
  logic        illegal;

  instruction_element_t head;
  assign head = instruction_element_t'(instr_o);

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .fls           (fls),
    .in_vld_i      (in_vld),
    .in_rdy_o      (in_rdy),
    .instr_i       (instr),
    .pc_i          (pc),
    .out_vld_o     (out_vld),
    .out_rdy_i     (out_rdy),
    .instruction_o (instr_o),
    .count_o       (count),
    .illegal_o     (illegal)
  );

  function automatic logic [31:0] mk_addi(int k);
    logic [11:0] imm;
    logic [4:0]  rd;
    imm = 12'(k);
    rd  = 5'(k);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  task automatic test_reset();
    rst = 1'b1; fls = 1'b0; in_vld = 1'b0;
    out_rdy = 1'b0; instr = '0; pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_rdy: got %b want 1", in_rdy);
    end
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_vld: got %b want 0", out_vld);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal: got %b want 0", illegal);
    end
  endtask

  task automatic test_addi();
    @(negedge clk);
    in_vld = 1'b1; instr = 32'h00500093; pc = 32'h60;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b1) begin
      errors++;
      $display("FAIL addi_vld: got %b want 1", out_vld);
    end
    checks++;
    if (head.instr !== imm_add) begin
      errors++;
      $display("FAIL addi_op: got %0d want %0d",
               head.instr, imm_add);
    end
    checks++;
    if ({head.cb1, head.cb2} !== 2'b10) begin
      errors++;
      $display("FAIL addi_cb: got %b%b want 10",
               head.cb1, head.cb2);
    end
    checks++;
    if (head.val1 !== 32'd0 || head.val2 !== 32'd5) begin
      errors++;
      $display("FAIL addi_vals: got %h/%h want 0/5",
               head.val1, head.val2);
    end
    checks++;
    if (head.dest_reg !== 5'd1 || head.pc !== 32'h60) begin
      errors++;
      $display("FAIL addi_rd_pc: got %0d/%h want 1/60",
               head.dest_reg, head.pc);
    end
    checks++;
    if (count !== 3'd1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL addi_cnt_ill: got %0d/%b want 1/0",
               count, illegal);
    end
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL addi_pop: got %0d/%b want 0/0",
               count, out_vld);
    end
  endtask

  task automatic test_decode_table();
    logic [31:0] w [7];
    instruction_element_t e [7];
    w[0] = 32'h12345137;
    w[1] = 32'hFE208CE3;
    w[2] = 32'hFE532E23;
    w[3] = 32'h402081B3;
    w[4] = 32'h4030D213;
    w[5] = 32'hFF042383;
    w[6] = 32'h00001297;
    for (int i = 0; i < 7; i++) begin
      e[i] = '0;
      e[i].pc = 32'h200;
    end
    e[0].instr = i_lui; e[0].val2 = 32'h12345000;
    e[0].dest_reg = 5'd2;
    e[1].instr = i_beq; e[1].cb1 = 1; e[1].cb2 = 1;
    e[1].val1 = 1; e[1].val2 = 2; e[1].branch = 1;
    e[1].b_imm = 32'hFFFFFFF8;
    e[2].instr = i_sw; e[2].cb1 = 1; e[2].cb2 = 1;
    e[2].val1 = 6; e[2].val2 = 5;
    e[2].b_imm = 32'hFFFFFFFC;
    e[3].instr = reg_sub; e[3].cb1 = 1; e[3].cb2 = 1;
    e[3].val1 = 1; e[3].val2 = 2; e[3].dest_reg = 5'd3;
    e[4].instr = imm_sra; e[4].cb1 = 1;
    e[4].val1 = 1; e[4].val2 = 32'h403;
    e[4].dest_reg = 5'd4;
    e[5].instr = i_lw; e[5].cb1 = 1; e[5].val1 = 8;
    e[5].b_imm = 32'hFFFFFFF0; e[5].dest_reg = 5'd7;
    e[6].instr = i_auipc; e[6].val1 = 32'h200;
    e[6].val2 = 32'h1000; e[6].dest_reg = 5'd5;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_vld = 1'b1; instr = w[i]; pc = 32'h200;
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      #1;
      checks++;
      if (out_vld !== 1'b1 || head !== e[i]) begin
        errors++;
        $display("FAIL decode_%0d: got %b/%h want 1/%h",
                 i, out_vld, head, e[i]);
      end
      out_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_rdy = 1'b0;
    end
  endtask

  task automatic test_full();
    out_rdy = 1'b0;
    pc = 32'h300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_vld = 1'b1; instr = mk_addi(i + 1);
      #1;
      checks++;
      if (in_rdy !== 1'b1) begin
        errors++;
        $display("FAIL full_rdy_%0d: got %b want 1",
                 i, in_rdy);
      end
      @(posedge clk);
    end
    @(negedge clk);
    instr = mk_addi(5);
    #1;
    checks++;
    if (count !== 3'd4 || in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got %0d/%b want 4/0",
               count, in_rdy);
    end
    out_rdy = 1'b1;
    #1;
    checks++;
    if (head.val2 !== 32'd1) begin
      errors++;
      $display("FAIL full_head: got %0d want 1", head.val2);
    end
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1 || count !== 3'd3) begin
      errors++;
      $display("FAIL full_after_pop: got %b/%0d want 1/3",
               in_rdy, count);
    end
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL full_refill: got %0d want 4", count);
    end
    out_rdy = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      #1;
      checks++;
      if (out_vld !== 1'b1 || head.val2 !== 32'(k)) begin
        errors++;
        $display("FAIL full_order_%0d: got %b/%0d want 1/%0d",
                 k, out_vld, head.val2, k);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_rdy = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: got %0d/%b want 0/0",
               count, out_vld);
    end
  endtask

  task automatic test_back_to_back();
    pc = 32'h400;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      in_vld = 1'b1; instr = mk_addi(i);
      @(posedge clk);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_vld = 1'b1; out_rdy = 1'b1;
      instr = mk_addi(3 + c);
      #1;
      checks++;
      if (head.val2 !== 32'(1 + c) || count !== 3'd2) begin
        errors++;
        $display("FAIL b2b_%0d: got %0d/%0d want %0d/2",
                 c, head.val2, count, 1 + c);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_vld = 1'b0;
    for (int k = 11; k <= 12; k++) begin
      #1;
      checks++;
      if (out_vld !== 1'b1 || head.val2 !== 32'(k)) begin
        errors++;
        $display("FAIL b2b_tail_%0d: got %b/%0d want 1/%0d",
                 k, out_vld, head.val2, k);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_rdy = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_empty: got %0d want 0", count);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = 32'hFFFFFFFF;
    bad[1] = 32'h00002063;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_vld = 1'b1; instr = bad[i];
      #1;
      checks++;
      if (in_rdy !== 1'b1) begin
        errors++;
        $display("FAIL ill_rdy_%0d: got %b want 1", i, in_rdy);
      end
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      #1;
      checks++;
      if (illegal !== 1'b1 || count !== 3'd0 ||
          out_vld !== 1'b0) begin
        errors++;
        $display("FAIL ill_pulse_%0d: got %b/%0d/%b want 1/0/0",
                 i, illegal, count, out_vld);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (illegal !== 1'b0) begin
        errors++;
        $display("FAIL ill_clear_%0d: got %b want 0",
                 i, illegal);
      end
    end
  endtask

  task automatic test_flush();
    pc = 32'h500;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      in_vld = 1'b1; instr = mk_addi(i);
      @(posedge clk);
    end
    @(negedge clk);
    fls = 1'b1; in_vld = 1'b1; out_rdy = 1'b1;
    instr = mk_addi(9);
    @(posedge clk);
    @(negedge clk);
    fls = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_vld !== 1'b0 ||
        in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got %0d/%b/%b want 0/0/1",
               count, out_vld, in_rdy);
    end
    in_vld = 1'b1; instr = mk_addi(7);
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    checks++;
    if (head.val2 !== 32'd7 || count !== 3'd1) begin
      errors++;
      $display("FAIL flush_next: got %0d/%0d want 7/1",
               head.val2, count);
    end
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    out_rdy = 1'b1; in_vld = 1'b1;
    instr = 32'h008000EF; pc = 32'h700;
    #1;
`ifdef DECODE_QUEUE_BYPASS_EN
    checks++;
    if (out_vld !== 1'b1 || head.jal !== 1'b1 ||
        head.branch !== 1'b1 || head.val2 !== 32'd8) begin
      errors++;
      $display("FAIL byp_same: got %b/%b/%b/%0d want 1/1/1/8",
               out_vld, head.jal, head.branch, head.val2);
    end
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0; out_rdy = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL byp_count: got %0d/%b want 0/0",
               count, out_vld);
    end
`else
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL nobyp_same: got %b want 0", out_vld);
    end
    out_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b1 || head.jal !== 1'b1 ||
        head.branch !== 1'b1 || head.val1 !== 32'h700 ||
        head.val2 !== 32'd8 || count !== 3'd1) begin
      errors++;
      $display("FAIL nobyp_jal: got %b/%b/%b/%h/%0d/%0d",
               out_vld, head.jal, head.branch,
               head.val1, head.val2, count);
    end
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_decode_table();
    test_full();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
